dpr_fifo_ctrl: RTL and testbench
================================

// Module: dpr_fifo_ctrl
// PURPOSE
//  Pointer/flag controller that turns the synchronous dual-port RAM (dpr_sync) into a FIFO.
//  Sits directly upstream of the RAM: accepts push/pop requests and drives the RAM's
//  din/addr_wr/addr_rd/wr_en/rd_en/blk_select.
//  Produces full/empty/almost flags, an occupancy count, and rd_valid aligned with the RAM's
//  registered dout, which feeds the consumer directly.
// PARAMETERS
//  MEM_WIDTH  16    data width; must match the RAM
//  MEM_DEPTH  1024  entries; must equal 2**ADDR_SIZE
//  ADDR_SIZE  10    RAM address width
//  AFULL_TH   1020  almost_full asserts when count >= AFULL_TH
//  AEMPTY_TH  4     almost_empty asserts when count <= AEMPTY_TH
// PORTS
//  clk             in   1            clock, rising edge
//  rst             in   1            synchronous, active-high reset
//  push            in   1            write request from producer
//  din             in   MEM_WIDTH    write data from producer
//  pop             in   1            read request from consumer
//  ram_din         out  MEM_WIDTH    to RAM din (= din)
//  ram_addr_wr     out  ADDR_SIZE    to RAM addr_wr (= wr_ptr)
//  ram_addr_rd     out  ADDR_SIZE    to RAM addr_rd (= rd_ptr)
//  ram_wr_en       out  1            to RAM wr_en (= push accepted)
//  ram_rd_en       out  1            to RAM rd_en (= pop accepted)
//  ram_blk_select  out  1            to RAM blk_select (= ram_wr_en | ram_rd_en)
//  rd_valid        out  1            RAM dout holds popped word this cycle
//  count           out  ADDR_SIZE+1  occupancy, 0..MEM_DEPTH
//  full, empty     out  1            count==MEM_DEPTH / count==0
//  almost_full     out  1            count >= AFULL_TH
//  almost_empty    out  1            count <= AEMPTY_TH
//  overflow        out  1            see CONFIGURATION
//  underflow       out  1            see CONFIGURATION
// BEHAVIOUR
//  - State: wr_ptr, rd_ptr (ADDR_SIZE), count (ADDR_SIZE+1), rd_valid. All registered, all 0 on rst.
//  - Reset values: count=0, empty=1, full=0, almost_empty=1, almost_full=0, rd_valid=0,
//    overflow=underflow=0.
//  - push_acc = push & ~full & ~rst; pop_acc = pop & ~empty & ~rst. Flags use registered count only.
//  - RAM controls are combinational from push_acc/pop_acc and pointers; all RAM enables are 0 while rst=1.
//  - Pointers: wr_ptr += push_acc, rd_ptr += pop_acc. Wrap MEM_DEPTH-1 -> 0 via natural ADDR_SIZE overflow.
//  - count: +1 push_acc only; -1 pop_acc only; unchanged if both or neither.
//  - Full + push + pop: pop accepted, push rejected; count becomes MEM_DEPTH-1.
//  - Empty + push + pop: push accepted, pop rejected (no fall-through); count becomes 1.
//  - Read latency: pop_acc in cycle N -> rd_valid=1 in cycle N+1, with RAM dout = popped word.
//    Back-to-back pops give one word per cycle.
//  - Write latency: word pushed in cycle N is poppable from cycle N+1 (empty deasserts at N+1).
//  - flags/count update on the edge ending the accepting cycle; no combinational path push/pop -> flags.
//  - Reset mid-operation: pointers/count cleared next edge; in-flight rd_valid dropped.
//    RAM contents are not cleared; stale data is unreachable.
// CONFIGURATION
//  FIFO_ERR_FLAGS_EN defined:
//    overflow  = registered 1-cycle pulse, cycle after push while full (push rejected).
//    underflow = registered 1-cycle pulse, cycle after pop while empty (pop rejected).
//    Not asserted for the accepted-pop case (full+push+pop) or accepted-push case (empty+push+pop).
//  FIFO_ERR_FLAGS_EN undefined: overflow/underflow ports present, tied to 0, no extra flops.
// TESTING  (bench config: MEM_DEPTH=16, ADDR_SIZE=4, AFULL_TH=14, AEMPTY_TH=2)
//  1 Reset: rst=1 for 2 cycles with push=pop=1 -> ram_wr_en=ram_rd_en=0, count=0, empty=1, rd_valid=0.
//  2 Fill/drain: push 0x0000..0x000F on 16 cycles -> full=1, count=16, almost_full from count=14;
//    17th push ignored (overflow pulse if EN).
//    Pop 16 -> rd_valid each next cycle, data 0x0000..0x000F in order, empty=1.
//  3 Wrap: push 10, pop 10, push 12 (0xA000..0xA00B) -> wr_ptr wraps to 6;
//    pops return 0xA000..0xA00B in order.
//  4 Simultaneous: at count=16 push+pop -> count=15, ram_wr_en=0.
//    At count=0 push+pop -> count=1, rd_valid=0 next cycle.
//    At count=5 push+pop -> count stays 5.
//  5 Underflow: pop when empty -> ram_rd_en=0, rd_valid=0, underflow=1 for one cycle if EN, else 0.
//  6 Mid-op reset: count=7, rst for 1 cycle during pop -> count=0, rd_valid=0, empty=1.
//    Next push/pop of 0x1234 returns 0x1234.

Source files
------------

// File: rtl/dpr_fifo_ctrl.sv
// dpr_fifo_ctrl -- pointer/flag controller that turns a synchronous dual-port
// RAM (dpr_sync) into a FIFO. Sits directly upstream of the RAM. The RAM's
// registered dout feeds the consumer and is qualified by rd_valid.
//
// Ports
//   clk, rst          clock (rising edge), synchronous active-high reset
//   push, din         producer write request + data
//   pop               consumer read request
//   ram_din           RAM din            (= din)
//   ram_addr_wr       RAM addr_wr        (= wr_ptr)
//   ram_addr_rd       RAM addr_rd        (= rd_ptr)
//   ram_wr_en         RAM wr_en          (= push accepted)
//   ram_rd_en         RAM rd_en          (= pop accepted)
//   ram_blk_select    RAM blk_select     (= ram_wr_en | ram_rd_en)
//   rd_valid          RAM dout holds the popped word this cycle
//   count             occupancy 0..MEM_DEPTH
//   full/empty        count==MEM_DEPTH / count==0
//   almost_full       count >= AFULL_TH
//   almost_empty      count <= AEMPTY_TH
//   overflow          1-cycle pulse after a rejected push (FIFO_ERR_FLAGS_EN)
//   underflow         1-cycle pulse after a rejected pop  (FIFO_ERR_FLAGS_EN)
//
// Build option: define FIFO_ERR_FLAGS_EN to enable the overflow/underflow
// pulses; otherwise both ports are tied to 0 and no flops are built for them.

module dpr_fifo_ctrl #(
   parameter int MEM_WIDTH = 16,
   parameter int MEM_DEPTH = 1024,
   parameter int ADDR_SIZE = 10,
   parameter int AFULL_TH  = 1020,
   parameter int AEMPTY_TH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push,
   input  logic [MEM_WIDTH-1:0] din,
   input  logic                 pop,
   output logic [MEM_WIDTH-1:0] ram_din,
   output logic [ADDR_SIZE-1:0] ram_addr_wr,
   output logic [ADDR_SIZE-1:0] ram_addr_rd,
   output logic                 ram_wr_en,
   output logic                 ram_rd_en,
   output logic                 ram_blk_select,
   output logic                 rd_valid,
   output logic [ADDR_SIZE:0]   count,
   output logic                 full,
   output logic                 empty,
   output logic                 almost_full,
   output logic                 almost_empty,
   output logic                 overflow,
   output logic                 underflow
);

   localparam logic [ADDR_SIZE:0] DEPTH_C  = (ADDR_SIZE+1)'(MEM_DEPTH);
   localparam logic [ADDR_SIZE:0] AFULL_C  = (ADDR_SIZE+1)'(AFULL_TH);
   localparam logic [ADDR_SIZE:0] AEMPTY_C = (ADDR_SIZE+1)'(AEMPTY_TH);

   logic [ADDR_SIZE-1:0] wr_ptr, rd_ptr;
   logic [ADDR_SIZE:0]   cnt_q;
   logic                 rd_valid_q;
   logic                 push_acc, pop_acc;

   // Flags decode the registered count only, so there is no combinational
   // path from push/pop to any flag.
   assign full         = (cnt_q == DEPTH_C);
   assign empty        = (cnt_q == '0);
   assign almost_full  = (cnt_q >= AFULL_C);
   assign almost_empty = (cnt_q <= AEMPTY_C);
   assign count        = cnt_q;
   assign rd_valid     = rd_valid_q;

   // Full+push+pop accepts only the pop; empty+push+pop accepts only the push
   // (no fall-through). rst gates both so the RAM sees no enables in reset.
   assign push_acc = push & ~full  & ~rst;
   assign pop_acc  = pop  & ~empty & ~rst;

   assign ram_din        = din;
   assign ram_addr_wr    = wr_ptr;
   assign ram_addr_rd    = rd_ptr;
   assign ram_wr_en      = push_acc;
   assign ram_rd_en      = pop_acc;
   assign ram_blk_select = push_acc | pop_acc;

   // Pointers wrap through natural ADDR_SIZE overflow (MEM_DEPTH == 2**ADDR_SIZE).
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         cnt_q      <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         if (push_acc) wr_ptr <= wr_ptr + ADDR_SIZE'(1);
         if (pop_acc)  rd_ptr <= rd_ptr + ADDR_SIZE'(1);
         case ({push_acc, pop_acc})
            2'b10:   cnt_q <= cnt_q + (ADDR_SIZE+1)'(1);
            2'b01:   cnt_q <= cnt_q - (ADDR_SIZE+1)'(1);
            default: cnt_q <= cnt_q;
         endcase
         // RAM dout is registered, so the popped word is there one cycle later.
         rd_valid_q <= pop_acc;
      end
   end

`ifdef FIFO_ERR_FLAGS_EN
   logic ovf_q, unf_q;

   // A rejected request paired with an accepted opposite request is legal
   // traffic, not an error, hence the ~pop / ~push terms.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         ovf_q <= push & full  & ~pop;
         unf_q <= pop  & empty & ~push;
      end
   end

   assign overflow  = ovf_q;
   assign underflow = unf_q;
`else
   assign overflow  = 1'b0;
   assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_dpr_fifo_ctrl.sv
// Bench for dpr_fifo_ctrl: wraps the controller with a behavioural dual-port
// RAM, drives directed and random push/pop traffic, and checks against a
// queue-based FIFO model. Popped words go into a scoreboard queue; a separate
// monitor pops and compares whenever rd_valid is presented.

module tb_dpr_fifo_ctrl;
   localparam int W  = 16;
   localparam int D  = 16;
   localparam int A  = 4;
   localparam int AF = 14;
   localparam int AE = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          push = 1'b0, pop = 1'b0;
   logic [W-1:0]  din = '0;
   logic [W-1:0]  ram_din;
   logic [A-1:0]  ram_addr_wr, ram_addr_rd;
   logic          ram_wr_en, ram_rd_en, ram_blk_select, rd_valid;
   logic [A:0]    count;
   logic          full, empty, almost_full, almost_empty, overflow, underflow;

   always #5 clk = ~clk;

   dpr_fifo_ctrl #(.MEM_WIDTH(W), .MEM_DEPTH(D), .ADDR_SIZE(A),
                   .AFULL_TH(AF), .AEMPTY_TH(AE)) dut (
      .clk(clk), .rst(rst), .push(push), .din(din), .pop(pop),
      .ram_din(ram_din), .ram_addr_wr(ram_addr_wr), .ram_addr_rd(ram_addr_rd),
      .ram_wr_en(ram_wr_en), .ram_rd_en(ram_rd_en), .ram_blk_select(ram_blk_select),
      .rd_valid(rd_valid), .count(count), .full(full), .empty(empty),
      .almost_full(almost_full), .almost_empty(almost_empty),
      .overflow(overflow), .underflow(underflow));

   // Behavioural synchronous dual-port RAM with registered dout.
   logic [W-1:0] mem [D];
   logic [W-1:0] dout;
   always @(posedge clk) begin
      if (ram_blk_select && ram_wr_en) mem[ram_addr_wr] <= ram_din;
      if (ram_blk_select && ram_rd_en) dout <= mem[ram_addr_rd];
   end

   int unsigned ntot = 0, npass = 0;
   logic [W-1:0] mq[$];   // model FIFO contents
   logic [W-1:0] sb[$];   // words expected on dout, in order
   bit           armed = 0;
   bit           rv_exp = 0;
   bit           ovf_exp = 0, unf_exp = 0;
   int unsigned  npush = 0, npop = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      ntot++;
      if (act === exp) npass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Monitor: rd_valid timing and data order.
   always @(negedge clk) begin
      if (armed) begin
         chk("rd_valid", {31'd0, rd_valid}, {31'd0, rv_exp});
         if (rd_valid === 1'b1) begin
            if (sb.size() == 0) chk("rd_data_unexpected", 32'd1, 32'd0);
            else chk("rd_data", {16'd0, dout}, {16'd0, sb.pop_front()});
         end
      end
   end

   // One clock cycle of stimulus; model updated at the active edge.
   task automatic cyc(input bit r, input bit p, input bit o, input logic [W-1:0] d);
      bit wr, rd;
      int n;
      @(negedge clk);
      rst = r; push = p; pop = o; din = d;
      #1;
      n = mq.size();
      if (armed) begin
         chk("count",        {27'd0, count},        n);
         chk("full",         {31'd0, full},         {31'd0, n == D});
         chk("empty",        {31'd0, empty},        {31'd0, n == 0});
         chk("almost_full",  {31'd0, almost_full},  {31'd0, n >= AF});
         chk("almost_empty", {31'd0, almost_empty}, {31'd0, n <= AE});
         chk("overflow",     {31'd0, overflow},     {31'd0, ovf_exp});
         chk("underflow",    {31'd0, underflow},    {31'd0, unf_exp});
      end
      wr = p && !r && (n < D);
      rd = o && !r && (n > 0);
      chk("ram_wr_en",      {31'd0, ram_wr_en},      {31'd0, wr});
      chk("ram_rd_en",      {31'd0, ram_rd_en},      {31'd0, rd});
      chk("ram_blk_select", {31'd0, ram_blk_select}, {31'd0, wr || rd});
      if (wr) begin
         chk("ram_addr_wr", {28'd0, ram_addr_wr}, npush % D);
         chk("ram_din",     {16'd0, ram_din},     {16'd0, d});
      end
      if (rd) chk("ram_addr_rd", {28'd0, ram_addr_rd}, npop % D);
      @(posedge clk);
`ifdef FIFO_ERR_FLAGS_EN
      ovf_exp = p && !r && (n == D) && !o;
      unf_exp = o && !r && (n == 0) && !p;
`else
      ovf_exp = 0;
      unf_exp = 0;
`endif
      rv_exp = rd;
      if (rd) begin sb.push_back(mq.pop_front()); npop++; end
      if (wr) begin mq.push_back(d); npush++; end
      if (r) begin mq.delete(); npush = 0; npop = 0; armed = 1; end
   endtask

   task automatic push_n(input int k, input logic [W-1:0] base);
      for (int i = 0; i < k; i++) cyc(0, 1, 0, base + W'(i));
   endtask

   task automatic pop_n(input int k);
      for (int i = 0; i < k; i++) cyc(0, 0, 1, '0);
   endtask

   initial begin
      // Reset with both requests high: no RAM enables.
      cyc(1, 1, 1, 16'hDEAD);
      cyc(1, 1, 1, 16'hBEEF);
      // Fill, one push past full, drain.
      push_n(16, 16'h0000);
      cyc(0, 1, 0, 16'hFFFF);
      pop_n(16);
      cyc(0, 0, 0, '0);
      // Wrap the pointers.
      push_n(10, 16'hB000);
      pop_n(10);
      push_n(12, 16'hA000);
      pop_n(12);
      cyc(0, 0, 0, '0);
      // Simultaneous push+pop at full, empty and mid-level.
      push_n(16, 16'hC000);
      cyc(0, 1, 1, 16'hCFFF);
      pop_n(15);
      cyc(0, 1, 1, 16'hD000);
      cyc(0, 0, 0, '0);
      pop_n(1);
      push_n(5, 16'hE000);
      cyc(0, 1, 1, 16'hE100);
      pop_n(5);
      cyc(0, 0, 0, '0);
      // Pop while empty, twice.
      pop_n(2);
      cyc(0, 0, 0, '0);
      // Reset mid-operation while popping.
      push_n(7, 16'h7000);
      cyc(1, 0, 1, '0);
      cyc(0, 1, 0, 16'h1234);
      pop_n(1);
      cyc(0, 0, 0, '0);
      // Random traffic, alternating fill-biased and drain-biased phases.
      for (int ph = 0; ph < 8; ph++) begin
         for (int i = 0; i < 60; i++) begin
            bit r, p, o;
            r = ($urandom_range(0, 149) == 0);
            p = (ph % 2 == 0) ? ($urandom_range(0, 99) < 75) : ($urandom_range(0, 99) < 25);
            o = (ph % 2 == 0) ? ($urandom_range(0, 99) < 30) : ($urandom_range(0, 99) < 80);
            cyc(r, p, o, W'($urandom));
         end
      end
      // Drain whatever is left.
      while (mq.size() > 0) cyc(0, 0, 1, '0);
      cyc(0, 0, 0, '0);
      cyc(0, 0, 0, '0);
      chk("scoreboard_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end
endmodule
